// File: rtl/uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx : byte UART transmitter, 1 start / 8 data (LSB first) / 1 stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLOCKS_PER_BIT = 87
) (
  input  logic       clkTx,
  input  logic       reset,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       serialOutput,
  output logic       txBusy,
  output logic       txDone
);

  localparam logic [7:0] c_BIT_LAST = 8'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        done_q, done_d;
  logic        w_bit_end;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign w_bit_end    = (cnt_q == c_BIT_LAST);
  assign serialOutput = serial_q;
  assign txBusy       = (state_q != IDLE);
  assign txDone       = done_q;

  always_ff @(posedge clkTx or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // The line level for the next bit is decided here and registered, so the
  // output changes only on clock edges.
  always_comb begin
    state_d  = state_q;
    cnt_d    = w_bit_end ? 8'd0 : cnt_q + 8'd1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d    = 8'd0;
        idx_d    = 3'd0;
        serial_d = 1'b1;
        if (txStart) begin
          shift_d  = txData;
          serial_d = 1'b0;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^txData;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          serial_d = shift_q[0];
          state_d  = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (idx_q == 3'd7) begin
            idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            serial_d = parity_q;
            state_d  = PARITY;
`else
            serial_d = 1'b1;
            state_d  = STOP;
`endif
          end else begin
            idx_d    = idx_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            serial_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          serial_d = 1'b1;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          serial_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        cnt_d    = 8'd0;
        idx_d    = 3'd0;
        serial_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx : randomized self-checking bench for uart_tx (CLOCKS_PER_BIT 87 and 2).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int CPB_A = 87;
  localparam int CPB_B = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clkTx    = 1'b0;
  logic       reset    = 1'b0;
  logic       txStartA = 1'b0;
  logic       txStartB = 1'b0;
  logic [7:0] txDataA  = 8'h00;
  logic [7:0] txDataB  = 8'h00;
  logic       serA, busyA, doneA;
  logic       serB, busyB, doneB;

  int checks = 0;
  int errors = 0;

  always #5 clkTx = ~clkTx;

  uart_tx #(.CLOCKS_PER_BIT(CPB_A)) u_dut_a (
    .clkTx(clkTx), .reset(reset), .txStart(txStartA), .txData(txDataA),
    .serialOutput(serA), .txBusy(busyA), .txDone(doneA)
  );

  uart_tx #(.CLOCKS_PER_BIT(CPB_B)) u_dut_b (
    .clkTx(clkTx), .reset(reset), .txStart(txStartB), .txData(txDataB),
    .serialOutput(serB), .txBusy(busyB), .txDone(doneB)
  );

  // Reference: level of frame bit n for byte d (start, 8 data LSB first, [parity], stop).
  function automatic logic model_level(input logic [7:0] d, input int n);
    if (n == 0) return 1'b0;
    if (n <= 8) return d[n-1];
    if (NBITS == 11 && n == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic logic get_ser(input bit sel);
    return sel ? serB : serA;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busyB : busyA;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? doneB : doneA;
  endfunction

  task automatic drive(input bit sel, input logic s, input logic [7:0] d);
    if (sel) begin
      txStartB = s;
      txDataB  = d;
    end else begin
      txStartA = s;
      txDataA  = d;
    end
  endtask

  // Called just after a falling edge; sends d and checks every cycle of the frame.
  // Returns at the falling edge inside the txDone cycle.
  task automatic run_frame(input bit sel, input logic [7:0] d, input logic hold,
                           input logic [7:0] data_after, input int inj_at, input string tag);
    int          cpb;
    int          len;
    logic [10:0] rxbits;
    logic [7:0]  rxbyte;
    cpb    = sel ? CPB_B : CPB_A;
    len    = NBITS * cpb;
    rxbits = '1;
    checks++;
    if (get_busy(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s accept_idle: txBusy=%b required 0", tag, get_busy(sel));
    end
    drive(sel, 1'b1, d);
    @(posedge clkTx);
    #1;
    drive(sel, hold, data_after);
    for (int t = 0; t < len; t++) begin
      @(negedge clkTx);
      if (inj_at != 0 && t == inj_at) drive(sel, 1'b1, 8'h12);
      else if (inj_at != 0 && t == inj_at + 1) drive(sel, 1'b0, 8'h12);
      checks++;
      if (get_ser(sel) !== model_level(d, t / cpb)) begin
        errors++;
        $display("FAIL %s line t=%0d: got %b required %b", tag, t, get_ser(sel), model_level(d, t / cpb));
      end
      checks++;
      if (get_busy(sel) !== 1'b1 || get_done(sel) !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_done t=%0d: got busy=%b done=%b required 1/0", tag, t, get_busy(sel), get_done(sel));
      end
      if (t % cpb == cpb / 2) rxbits[t / cpb] = get_ser(sel);
    end
    @(negedge clkTx);
    checks++;
    if (get_done(sel) !== 1'b1 || get_busy(sel) !== 1'b0 || get_ser(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s end_of_frame: got done=%b busy=%b line=%b required 1/0/1", tag, get_done(sel), get_busy(sel), get_ser(sel));
    end
    rxbyte = rxbits[8:1];
    checks++;
    if (rxbyte !== d || rxbits[0] !== 1'b0 || rxbits[NBITS-1] !== 1'b1) begin
      errors++;
      $display("FAIL %s receiver: got byte %h start %b stop %b required %h 0 1", tag, rxbyte, rxbits[0], rxbits[NBITS-1], d);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (serA !== 1'b1 || busyA !== 1'b0 || doneA !== 1'b0 ||
        serB !== 1'b1 || busyB !== 1'b0 || doneB !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got A=%b%b%b B=%b%b%b required 100/100", serA, busyA, doneA, serB, busyB, doneB);
    end
    repeat (3) @(negedge clkTx);
    reset = 1'b0;
    @(negedge clkTx);
    checks++;
    if (serA !== 1'b1 || busyA !== 1'b0 || doneA !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b%b%b required 100", serA, busyA, doneA);
    end
  endtask

  task automatic test_known_bytes();
    run_frame(1'b0, 8'h55, 1'b0, 8'h55, 0, "byte_55");
    run_frame(1'b0, 8'hA3, 1'b0, 8'hA3, 0, "byte_A3");
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      run_frame(1'b0, d, 1'b0, 8'($urandom), 0, "random");
      repeat ($urandom_range(0, 3)) @(negedge clkTx);
    end
  endtask

  task automatic test_ignore_busy();
    logic [7:0] d;
    d = 8'($urandom);
    run_frame(1'b0, d, 1'b0, 8'($urandom), 300, "ignore_busy");
    for (int t = 0; t < 3 * CPB_A; t++) begin
      @(negedge clkTx);
      checks++;
      if (serA !== 1'b1 || busyA !== 1'b0) begin
        errors++;
        $display("FAIL no_second_frame t=%0d: got line=%b busy=%b required 1/0", t, serA, busyA);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_frame(1'b0, 8'h0F, 1'b1, 8'hF0, 0, "b2b_first");
    run_frame(1'b0, 8'hF0, 1'b0, 8'hF0, 0, "b2b_second");
  endtask

  task automatic test_reset_midframe();
    drive(1'b0, 1'b1, 8'($urandom_range(0, 127)));
    @(posedge clkTx);
    #1;
    drive(1'b0, 1'b0, 8'h00);
    repeat (400) @(negedge clkTx);
    reset = 1'b1;
    #1;
    checks++;
    if (serA !== 1'b1 || busyA !== 1'b0 || doneA !== 1'b0) begin
      errors++;
      $display("FAIL reset_midframe: got line=%b busy=%b done=%b required 1/0/0", serA, busyA, doneA);
    end
    @(negedge clkTx);
    reset = 1'b0;
    run_frame(1'b0, 8'h81, 1'b0, 8'h81, 0, "after_reset_81");
  endtask

  task automatic test_fast_clock();
    run_frame(1'b1, 8'hFF, 1'b0, 8'hFF, 0, "cpb2_FF");
    for (int i = 0; i < 4; i++) run_frame(1'b1, 8'($urandom), 1'b0, 8'($urandom), 0, "cpb2_random");
  endtask

  initial begin
    test_reset();
    test_known_bytes();
    test_random();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midframe();
    test_fast_clock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
